hyperbus_delay_line: RTL and testbench
======================================

# hyperbus_delay_line

Clocked, synthesizable delay line for HyperBus PHY signals. It delays a `WIDTH`-bit bundle by a run-time programmable number of clock cycles, selected from `MAX_DELAY` taps. Retuning is glitch-free: while a new delay settles, the output is frozen and `busy_o` is asserted. The block sits between the PHY capture/launch registers and the pads, and is the cycle-accurate replacement for behavioural time-based delay models in both simulation and synthesis.

## Interface
- `WIDTH`, default 8: bits per delayed bundle.
- `MAX_DELAY`, default 16: number of taps; legal delays are 0..`MAX_DELAY`-1. Must be ≥ 2.
- `RESET_DELAY`, default 0: active delay after reset. Must be < `MAX_DELAY`.
- `DW`, derived: $clog2(`MAX_DELAY`).

Ports:
- `clk_i` input 1: clock. One clock; reset is asynchronous and active-high.
- `rst_i` input 1: asynchronous, active-high reset.
- `en_i` input 1: shift enable. When low, the pipeline, `out_o` and the hold counter freeze.
- `data_i` input `WIDTH`: bundle to delay.
- `delay_i` input `DW`: requested delay in cycles. Values ≥ `MAX_DELAY` are clamped to `MAX_DELAY`-1.
- `out_o` output `WIDTH`: delayed bundle (registered).
- `busy_o` output 1: retune in progress; `out_o` is frozen.
- `delay_o` output `DW`: currently active delay.

## Operation
- Pipeline `pipe[0..MAX_DELAY-1]`. On each `en_i` edge: `pipe[0]<=data_i` and `pipe[k]<=pipe[k-1]`.
- Tap: with active delay d, tap = `data_i` when d=0, else `pipe[d-1]`. In IDLE with `en_i`=1, `out_o<=tap` every edge.
- FSM states:
  - IDLE: `busy_o`=0. If `en_i` and clamp(`delay_i`) ≠ active delay: `pending<=clamp(delay_i)`, `cnt<=MAX_DELAY-1`, go to HOLD.
  - HOLD: `busy_o`=1 and `out_o` holds its last value; the pipeline keeps shifting.
    - If clamp(`delay_i`) ≠ `pending`: reload `pending` and set `cnt<=MAX_DELAY-1` (restart).
    - Else if `cnt`=0: `active<=pending` and go to IDLE.
    - Else `cnt<=cnt-1`.
- `en_i`=0 in any state: FSM, counter, pipeline and `out_o` all hold.
- A request equal to the active delay while in IDLE is a no-op.
- In HOLD, a request equal to the old active delay is still a retune, because it differs from `pending`.
- Reset (asynchronous, any time, including mid-HOLD): pipeline=0, `out_o`=0, `busy_o`=0, `delay_o`=`RESET_DELAY`, state IDLE, `cnt`=0, `pending`=`RESET_DELAY`. Any retune in progress is discarded.

## Timing
- Latency in IDLE with a constant delay d: a value on `data_i` at edge t appears on `out_o` after edge t+d, i.e. d+1 edges including the output register. No bubbles.
- Retune: `delay_i` changes before edge T0.
  - Edge T0: enter HOLD; `busy_o`=1 from T0.
  - HOLD lasts exactly `MAX_DELAY` enabled edges, T0+1..T0+`MAX_DELAY`.
  - At edge T0+`MAX_DELAY`: `delay_o` updates and `busy_o` falls.
  - First `out_o` from the new tap: edge T0+`MAX_DELAY`+1.
- While frozen, `out_o` equals the value registered at edge T0-1.
- Disabled cycles stretch every count above one-for-one.
- All outputs come directly from flops.

## Test plan
- **Reset values:** assert `rst_i` mid-cycle with `RESET_DELAY`=3 → `out_o`=0x00, `busy_o`=0 and `delay_o`=3 immediately (asynchronous). After release, a ramp 0x01,0x02,… reaches `out_o` 4 edges later.
- **Latency sweep:** `delay_i`=0, 5, 15 (each after its retune completes), with a counter stream on `data_i` → `out_o` lags by 1, 6 and 16 edges respectively.
- **Retune freeze:** from delay 2, set `delay_i`=9 → `busy_o` high for exactly 16 edges, `out_o` constant at its last value, `delay_o` goes from 2 to 9 on the 16th edge, and the new stream lags by 10 edges.
- **Restart mid-hold:** set 9, then after 7 HOLD edges set 4 → `pending`=4 and the counter restarts. `busy_o` totals 7+16 edges and the final `delay_o`=4.
- **Clamp and no-op:** with `MAX_DELAY`=12 (`DW`=4), `delay_i`=14 → active delay 11. Re-writing 11 from IDLE → no HOLD, `busy_o` stays 0.
- **Enable gating:** deassert `en_i` for 5 cycles in IDLE and again during HOLD → `out_o`, pipeline and counter freeze. HOLD ends 5 edges later than it would otherwise, and the data sequence is unbroken.

Source files
------------

// File: rtl/hyperbus_delay_line.sv
// Cycle-accurate programmable delay line for HyperBus PHY signal bundles.
// Retuning freezes out_o and raises busy_o until the newly selected tap is safe to use.
module hyperbus_delay_line #(
    parameter int unsigned WIDTH       = 8,
    parameter int unsigned MAX_DELAY   = 16,
    parameter int unsigned RESET_DELAY = 0,
    localparam int unsigned DW         = $clog2(MAX_DELAY)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             en_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic [DW-1:0]    delay_i,
    output logic [WIDTH-1:0] out_o,
    output logic             busy_o,
    output logic [DW-1:0]    delay_o
);

    typedef enum logic {StIdle, StHold} state_e;

    localparam logic [DW-1:0] MaxTap   = DW'(MAX_DELAY - 1);
    localparam logic [DW-1:0] ResetTap = DW'(RESET_DELAY);

    state_e           state_q;
    logic [WIDTH-1:0] pipe_q [MAX_DELAY];
    logic [DW-1:0]    active_q;
    logic [DW-1:0]    pending_q;
    logic [DW-1:0]    cnt_q;
    logic [DW-1:0]    req;
    logic [WIDTH-1:0] tap;

    always_comb begin
        req = delay_i;
        if (delay_i > MaxTap) begin
            req = MaxTap;
        end
    end

    // Delay 0 bypasses the pipeline so the output register alone gives one cycle of latency.
    always_comb begin
        tap = data_i;
        if (active_q != '0) begin
            tap = pipe_q[active_q - 1'b1];
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int unsigned i = 0; i < MAX_DELAY; i++) begin
                pipe_q[i] <= '0;
            end
            out_o     <= '0;
            busy_o    <= 1'b0;
            active_q  <= ResetTap;
            pending_q <= ResetTap;
            cnt_q     <= '0;
            state_q   <= StIdle;
        end else if (en_i) begin
            pipe_q[0] <= data_i;
            for (int unsigned i = 1; i < MAX_DELAY; i++) begin
                pipe_q[i] <= pipe_q[i-1];
            end
            case (state_q)
                StIdle: begin
                    // The retune edge itself already freezes out_o at the previous value.
                    if (req != active_q) begin
                        pending_q <= req;
                        cnt_q     <= MaxTap;
                        state_q   <= StHold;
                        busy_o    <= 1'b1;
                    end else begin
                        out_o <= tap;
                    end
                end
                StHold: begin
                    if (req != pending_q) begin
                        pending_q <= req;
                        cnt_q     <= MaxTap;
                    end else if (cnt_q == '0) begin
                        active_q <= pending_q;
                        state_q  <= StIdle;
                        busy_o   <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                default: begin
                    state_q <= StIdle;
                    busy_o  <= 1'b0;
                end
            endcase
        end
    end

    assign delay_o = active_q;

endmodule

// File: tb/tb_hyperbus_delay_line.sv
// Bench for hyperbus_delay_line: a 16-tap instance (reset delay 3) and a 12-tap instance
// for clamping, driven with a ramp and checked against a scoreboard of in-flight values.
module tb_hyperbus_delay_line;

    logic       clk;
    logic       rst;
    logic       en;
    logic [7:0] data;
    logic [3:0] dly;
    logic [3:0] dly12;
    logic [7:0] out;
    logic [7:0] out12;
    logic       busy;
    logic       busy12;
    logic [3:0] dlyo;
    logic [3:0] dlyo12;

    int tests;
    int fails;
    int n;          // enabled edges since reset release; ramp value k is driven on edge k
    int act_d;
    int act_d12;

    typedef struct {
        logic [3:0] delay;
        int         lag;
        int         busy_edges;
    } sweep_t;

    sweep_t sweep [3];

    hyperbus_delay_line #(
        .WIDTH       (8),
        .MAX_DELAY   (16),
        .RESET_DELAY (3)
    ) dut (
        .clk_i   (clk),
        .rst_i   (rst),
        .en_i    (en),
        .data_i  (data),
        .delay_i (dly),
        .out_o   (out),
        .busy_o  (busy),
        .delay_o (dlyo)
    );

    hyperbus_delay_line #(
        .WIDTH       (8),
        .MAX_DELAY   (12),
        .RESET_DELAY (0)
    ) dut12 (
        .clk_i   (clk),
        .rst_i   (rst),
        .en_i    (en),
        .data_i  (data),
        .delay_i (dly12),
        .out_o   (out12),
        .busy_o  (busy12),
        .delay_o (dlyo12)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, required $finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [7:0] ramp_at(input int k);
        return (k >= 1) ? 8'(k) : 8'h00;
    endfunction

    function automatic logic [7:0] cur_out(input bit sel);
        return sel ? out12 : out;
    endfunction

    function automatic logic cur_busy(input bit sel);
        return sel ? busy12 : busy;
    endfunction

    function automatic logic [3:0] cur_dly(input bit sel);
        return sel ? dlyo12 : dlyo;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        data = 8'(n + 1);
        @(posedge clk);
        #1;
        if (en) n++;
    endtask

    // Scoreboard: values already in the pipeline are preloaded, each driven value is pushed,
    // and one is popped per enabled edge once the delay is covered.
    task automatic track(input bit sel, input int d, input int cycles, input int gap_at,
                         input string name);
        logic [7:0] sb [$];
        logic [7:0] expv;
        logic [7:0] last;
        bit         was_en;
        for (int k = n - d + 1; k <= n; k++) sb.push_back(ramp_at(k));
        last = ramp_at(n - d);
        for (int c = 0; c < cycles; c++) begin
            if (gap_at > 0 && c == gap_at) en = 1'b0;
            if (gap_at > 0 && c == gap_at + 5) en = 1'b1;
            was_en = en;
            if (was_en) sb.push_back(8'(n + 1));
            step();
            if (was_en) begin
                expv = sb.pop_front();
                last = expv;
            end else begin
                expv = last;
            end
            check({name, "_out"}, 32'(cur_out(sel)), 32'(expv));
        end
        en = 1'b1;
        check({name, "_busy"}, 32'(cur_busy(sel)), 32'd0);
    endtask

    task automatic retune(input bit sel, input logic [3:0] d, input int gap_at,
                          input int exp_busy, input logic [3:0] exp_dly, input string name);
        logic [7:0] exp_frz;
        logic [7:0] seen;
        logic [3:0] old_d;
        logic [3:0] seen_d;
        int         nb;
        old_d   = 4'(sel ? act_d12 : act_d);
        exp_frz = ramp_at(n - int'(old_d));
        seen    = exp_frz;
        seen_d  = old_d;
        if (sel) dly12 = d;
        else dly = d;
        step();
        nb = 0;
        for (int i = 0; i < 100 && cur_busy(sel); i++) begin
            nb++;
            if (cur_out(sel) !== exp_frz) seen = cur_out(sel);
            if (cur_dly(sel) !== old_d) seen_d = cur_dly(sel);
            if (gap_at > 0 && nb == gap_at) en = 1'b0;
            if (gap_at > 0 && nb == gap_at + 5) en = 1'b1;
            step();
        end
        en = 1'b1;
        check({name, "_busy_edges"}, 32'(nb), 32'(exp_busy));
        check({name, "_frozen_out"}, 32'(seen), 32'(exp_frz));
        check({name, "_old_delay_in_hold"}, 32'(seen_d), 32'(old_d));
        check({name, "_new_delay"}, 32'(cur_dly(sel)), 32'(exp_dly));
        if (sel) act_d12 = int'(exp_dly);
        else act_d = int'(exp_dly);
    endtask

    initial begin
        logic [7:0] exp_frz;
        logic [7:0] seen;
        int         nb;

        sweep[0] = '{delay: 4'd0,  lag: 1,  busy_edges: 16};
        sweep[1] = '{delay: 4'd5,  lag: 6,  busy_edges: 16};
        sweep[2] = '{delay: 4'd15, lag: 16, busy_edges: 16};

        tests = 0;
        fails = 0;
        n = 0;
        act_d = 3;
        act_d12 = 0;
        rst = 1'b0;
        en = 1'b0;
        data = 8'h00;
        dly = 4'd3;
        dly12 = 4'd0;

        // Asynchronous reset asserted between clock edges
        #12 rst = 1'b1;
        #1;
        check("reset_out", 32'(out), 32'h00);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_delay", 32'(dlyo), 32'd3);
        check("reset_delay12", 32'(dlyo12), 32'd0);
        @(posedge clk);
        #2;
        rst = 1'b0;
        en = 1'b1;
        n = 0;

        track(0, 3, 10, 0, "reset_ramp");

        for (int i = 0; i < 3; i++) begin
            retune(0, sweep[i].delay, 0, sweep[i].busy_edges, sweep[i].delay, "sweep");
            track(0, sweep[i].lag - 1, 24, 0, "sweep_lag");
        end

        retune(0, 4'd2, 0, 16, 4'd2, "to2");
        track(0, 2, 8, 0, "lag3");
        retune(0, 4'd9, 0, 16, 4'd9, "freeze2to9");
        track(0, 9, 16, 0, "lag10");

        // Restart: request 9, then 4 after seven busy samples
        retune(0, 4'd1, 0, 16, 4'd1, "to1");
        track(0, 1, 8, 0, "lag2");
        exp_frz = ramp_at(n - act_d);
        seen = exp_frz;
        dly = 4'd9;
        step();
        nb = 0;
        for (int i = 0; i < 100 && busy; i++) begin
            nb++;
            if (out !== exp_frz) seen = out;
            if (nb == 7) dly = 4'd4;
            step();
        end
        check("restart_busy_edges", 32'(nb), 32'd23);
        check("restart_frozen_out", 32'(seen), 32'(exp_frz));
        check("restart_delay", 32'(dlyo), 32'd4);
        act_d = 4;
        track(0, 4, 12, 0, "restart_lag5");

        track(0, 4, 20, 6, "gate_idle");
        retune(0, 4'd7, 3, 21, 4'd7, "gate_hold");
        track(0, 7, 16, 0, "gate_hold_lag8");

        retune(1, 4'd14, 0, 12, 4'd11, "clamp14");
        track(1, 11, 16, 0, "clamp_lag12");
        dly12 = 4'd11;
        for (int i = 0; i < 4; i++) begin
            step();
            check("noop11_busy", 32'(busy12), 32'd0);
            check("noop11_delay", 32'(dlyo12), 32'd11);
        end
        dly12 = 4'd15;
        for (int i = 0; i < 4; i++) begin
            step();
            check("noop15_busy", 32'(busy12), 32'd0);
            check("noop15_delay", 32'(dlyo12), 32'd11);
        end

        // Reset in the middle of a retune discards it
        dly = 4'd10;
        step();
        step();
        step();
        check("midhold_busy_before", 32'(busy), 32'd1);
        #3 rst = 1'b1;
        #1;
        check("midhold_reset_out", 32'(out), 32'h00);
        check("midhold_reset_busy", 32'(busy), 32'd0);
        check("midhold_reset_delay", 32'(dlyo), 32'd3);
        check("midhold_reset_delay12", 32'(dlyo12), 32'd0);
        @(posedge clk);
        #1;
        dly = 4'd3;
        dly12 = 4'd0;
        act_d = 3;
        act_d12 = 0;
        #1;
        rst = 1'b0;
        n = 0;
        track(0, 3, 8, 0, "post_reset_ramp");
        track(1, 0, 4, 0, "post_reset_ramp12");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
